// File: rtl/serial_comparator_multi_digit_fsm.sv
// Serial magnitude comparator. Operands arrive DIGIT_W bits per cycle and are
// framed into words of WORD_DIGITS digits. Each word can be sent MSB-first or
// LSB-first, and operands can be unsigned or two's complement. The block gives
// a combinational running verdict and a registered per-word result with a
// one-cycle valid pulse.
module serial_comparator_multi_digit_fsm #(
    parameter int DIGIT_W     = 1,
    parameter int WORD_DIGITS = 8,
    parameter int SIGNED      = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic               msb_first,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               a_less_b,
    output logic               a_eq_b,
    output logic               a_greater_b,
    output logic               busy,
    output logic               result_valid,
    output logic               result_less,
    output logic               result_eq,
    output logic               result_greater
);

    // The counter keeps at least one bit so that WORD_DIGITS=1 still
    // elaborates. In that case it simply stays at zero.
    localparam int CW = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_DIGITS - 1);

    typedef enum logic [1:0] {
        st_equal       = 2'd0,
        st_a_less_b    = 2'd1,
        st_a_greater_b = 2'd2
    } state_t;

    state_t          state, state_next;
    state_t          res, res_next;
    state_t          dcmp, v;
    logic [CW-1:0]   cnt, cnt_next;
    logic            mode, mode_next;
    logic            rv_next;
    logic            first, last, eff_msb, sign_digit;
    logic [DIGIT_W-1:0] a_c, b_c;

    assign first      = (cnt == '0);
    assign last       = (cnt == LAST);
    // The order is taken live on the first digit and from the latched mode
    // afterwards, so msb_first toggling mid-word has no effect.
    assign eff_msb    = first ? msb_first : mode;
    assign sign_digit = eff_msb ? first : last;
    assign busy       = (cnt != '0);

    // Digit compare, running verdict and next-state/sequencing decisions
    always_comb begin
        a_c = a;
        b_c = b;
        // Flipping the top bit of both digits turns the unsigned compare
        // into a signed one for the sign digit.
        if (SIGNED != 0 && sign_digit) begin
            a_c[DIGIT_W-1] = ~a[DIGIT_W-1];
            b_c[DIGIT_W-1] = ~b[DIGIT_W-1];
        end
        if (a_c < b_c)      dcmp = st_a_less_b;
        else if (a_c > b_c) dcmp = st_a_greater_b;
        else                dcmp = st_equal;

        // MSB-first: the first differing digit decides.
        // LSB-first: each more significant differing digit overrides.
        v = state;
        if (valid) begin
            if (eff_msb) begin
                if (state == st_equal) v = dcmp;
            end else if (dcmp != st_equal) begin
                v = dcmp;
            end
        end

        state_next = state;
        cnt_next   = cnt;
        mode_next  = mode;
        res_next   = res;
        rv_next    = 1'b0;
        if (valid) begin
            if (first) mode_next = msb_first;
            if (last) begin
                res_next   = v;
                rv_next    = 1'b1;
                state_next = st_equal;
                cnt_next   = '0;
            end else begin
                state_next = v;
                cnt_next   = cnt + CW'(1);
            end
        end
    end

    // State, counter, order and result registers. Reset wins over valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= st_equal;
            cnt          <= '0;
            mode         <= 1'b0;
            res          <= st_equal;
            result_valid <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            mode         <= mode_next;
            res          <= res_next;
            result_valid <= rv_next;
        end
    end

    // One-hot decode of the running verdict and the held word result
    always_comb begin
        a_less_b       = (v == st_a_less_b);
        a_eq_b         = (v == st_equal);
        a_greater_b    = (v == st_a_greater_b);
        result_less    = (res == st_a_less_b);
        result_eq      = (res == st_equal);
        result_greater = (res == st_a_greater_b);
    end

endmodule

// File: tb/tb_serial_comparator_multi_digit_fsm.sv
// Scoreboard bench for serial_comparator_multi_digit_fsm. Three instances
// share one stimulus bus: 2x4 unsigned, 2x4 signed, and 1x1 unsigned. The
// last instance sees bit 0 of each digit. Expected running verdicts and word
// results come from a value-level model that compares numbers assembled from
// the digits received so far.
module tb_serial_comparator_multi_digit_fsm;

    localparam int N = 4;
    localparam logic [2:0] LT = 3'b100, EQ = 3'b010, GT = 3'b001;

    logic       clk = 1'b0;
    logic       rst, valid, msb_first;
    logic [1:0] a, b;

    logic lt0, eq0, gt0, busy0, rv0, rl0, re0, rg0;
    logic lt1, eq1, gt1, busy1, rv1, rl1, re1, rg1;
    logic lt2, eq2, gt2, busy2, rv2, rl2, re2, rg2;

    serial_comparator_multi_digit_fsm #(.DIGIT_W(2), .WORD_DIGITS(N), .SIGNED(0)) dut0 (
        .clk(clk), .rst(rst), .valid(valid), .msb_first(msb_first), .a(a), .b(b),
        .a_less_b(lt0), .a_eq_b(eq0), .a_greater_b(gt0), .busy(busy0),
        .result_valid(rv0), .result_less(rl0), .result_eq(re0), .result_greater(rg0));

    serial_comparator_multi_digit_fsm #(.DIGIT_W(2), .WORD_DIGITS(N), .SIGNED(1)) dut1 (
        .clk(clk), .rst(rst), .valid(valid), .msb_first(msb_first), .a(a), .b(b),
        .a_less_b(lt1), .a_eq_b(eq1), .a_greater_b(gt1), .busy(busy1),
        .result_valid(rv1), .result_less(rl1), .result_eq(re1), .result_greater(rg1));

    serial_comparator_multi_digit_fsm #(.DIGIT_W(1), .WORD_DIGITS(1), .SIGNED(0)) dut2 (
        .clk(clk), .rst(rst), .valid(valid), .msb_first(msb_first), .a(a[0:0]), .b(b[0:0]),
        .a_less_b(lt2), .a_eq_b(eq2), .a_greater_b(gt2), .busy(busy2),
        .result_valid(rv2), .result_less(rl2), .result_eq(re2), .result_greater(rg2));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] r0, r1, r2;
        logic       busy;
        logic       rstd;
    } exp_t;

    exp_t       cq[$];
    logic [2:0] rq0[$], rq1[$], rq2[$];

    int checks = 0, errors = 0;

    // model state for the word in progress
    logic [1:0] wa[N], wb[N];
    int         pos = 0;
    bit         word_msb = 1'b1;
    bit         just_reset = 1'b0;

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [2:0] rel(input longint x, input longint y);
        return (x < y) ? LT : (x > y) ? GT : EQ;
    endfunction

    // Numeric compare of the first k received digits. MSB-first: a k-digit
    // prefix, signed if requested. LSB-first: the low k digits, which only
    // become a signed number once the whole word has arrived.
    function automatic logic [2:0] verdict(input bit sgn, input int k);
        longint va = 0, vb = 0;
        for (int i = 0; i < k; i++) begin
            if (word_msb) begin
                va = (va << 2) | longint'(wa[i]);
                vb = (vb << 2) | longint'(wb[i]);
            end else begin
                va = va | (longint'(wa[i]) << (2 * i));
                vb = vb | (longint'(wb[i]) << (2 * i));
            end
        end
        if (sgn && k > 0 && (word_msb || k == N)) begin
            if (va[2*k-1]) va = va - (longint'(1) << (2 * k));
            if (vb[2*k-1]) vb = vb - (longint'(1) << (2 * k));
        end
        return rel(va, vb);
    endfunction

    // Drive one cycle of inputs, record expectations, advance to posedge+1.
    task automatic cycle(input bit v, input logic [1:0] da, input logic [1:0] db, input bit m);
        exp_t e;
        int   k;
        valid = v; a = da; b = db; msb_first = m;
        e.busy = (pos != 0);
        e.rstd = just_reset;
        just_reset = 1'b0;
        if (v) begin
            if (pos == 0) word_msb = m;
            wa[pos] = da;
            wb[pos] = db;
        end
        k = v ? pos + 1 : pos;
        e.r0 = verdict(1'b0, k);
        e.r1 = verdict(1'b1, k);
        e.r2 = v ? rel(longint'(da[0]), longint'(db[0])) : EQ;
        cq.push_back(e);
        if (v) begin
            rq2.push_back(e.r2);
            if (pos == N - 1) begin
                rq0.push_back(e.r0);
                rq1.push_back(e.r1);
                pos = 0;
            end else begin
                pos++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 2'($urandom), 2'($urandom), 1'($urandom));
        rst = 1'b0;
        pos = 0;
        just_reset = 1'b1;
    endtask

    // Send one 8-bit word. Optionally insert a stall before digit stall_at,
    // add random stalls, or abort with a reset before digit abort_at.
    task automatic send_word(input logic [7:0] xa, input logic [7:0] xb, input bit msb,
                             input int stall_at, input int stall_n, input int abort_at,
                             input bit rnd_stall);
        logic [1:0] da, db;
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            if (i == stall_at)
                repeat (stall_n) cycle(1'b0, 2'($urandom), 2'($urandom), 1'($urandom));
            if (rnd_stall && $urandom_range(3) == 0)
                repeat ($urandom_range(1, 3)) cycle(1'b0, 2'($urandom), 2'($urandom), 1'($urandom));
            da = msb ? xa[7-2*i -: 2] : xa[2*i +: 2];
            db = msb ? xb[7-2*i -: 2] : xb[2*i +: 2];
            cycle(1'b1, da, db, (i == 0) ? msb : 1'($urandom));
        end
    endtask

    // Monitor: check running verdict, busy, result pulses and held results.
    logic [2:0] hold0 = EQ, hold1 = EQ, hold2 = EQ;
    exp_t       me;
    always @(negedge clk) begin
        if (cq.size() > 0) begin
            me = cq.pop_front();
            if (me.rstd) begin
                hold0 = EQ; hold1 = EQ; hold2 = EQ;
            end
            if (rv0) begin
                if (rq0.size() == 0) chk("unexpected_result_valid0", 3'd1, 3'd0);
                else begin hold0 = rq0.pop_front(); chk("result0", {rl0, re0, rg0}, hold0); end
            end
            if (rv1) begin
                if (rq1.size() == 0) chk("unexpected_result_valid1", 3'd1, 3'd0);
                else begin hold1 = rq1.pop_front(); chk("result1", {rl1, re1, rg1}, hold1); end
            end
            if (rv2) begin
                if (rq2.size() == 0) chk("unexpected_result_valid2", 3'd1, 3'd0);
                else begin hold2 = rq2.pop_front(); chk("result2", {rl2, re2, rg2}, hold2); end
            end
            chk("held0", {rl0, re0, rg0}, hold0);
            chk("held1", {rl1, re1, rg1}, hold1);
            chk("held2", {rl2, re2, rg2}, hold2);
            chk("running0", {lt0, eq0, gt0}, me.r0);
            chk("running1", {lt1, eq1, gt1}, me.r1);
            chk("running2", {lt2, eq2, gt2}, me.r2);
            chk("busy0", {2'b0, busy0}, {2'b0, me.busy});
            chk("busy1", {2'b0, busy1}, {2'b0, me.busy});
            chk("busy2", {2'b0, busy2}, 3'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ra, rb;
        rst = 1'b1; valid = 1'b0; msb_first = 1'b1; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy0",  {2'b0, busy0}, 3'd0);
        chk("reset_rv0",    {2'b0, rv0},   3'd0);
        chk("reset_res0",   {rl0, re0, rg0}, EQ);
        chk("reset_run0",   {lt0, eq0, gt0}, EQ);
        chk("reset_res1",   {rl1, re1, rg1}, EQ);
        chk("reset_rv1",    {2'b0, rv1},   3'd0);
        chk("reset_res2",   {rl2, re2, rg2}, EQ);
        chk("reset_rv2",    {2'b0, rv2},   3'd0);
        @(posedge clk); #1;

        // Scenarios from the plan
        send_word(8'hA5, 8'hA3, 1'b1, -1, 0, N, 1'b0);
        send_word(8'hA5, 8'hA3, 1'b0, -1, 0, N, 1'b0);
        send_word(8'h80, 8'h01, 1'b1, -1, 0, N, 1'b0);
        send_word(8'hFF, 8'h00, 1'b0, -1, 0, N, 1'b0);
        send_word(8'hA5, 8'hA3, 1'b1, 2, 3, N, 1'b0);
        send_word(8'h3C, 8'h3C, 1'b1, -1, 0, N, 1'b0);
        send_word(8'h10, 8'h20, 1'b1, -1, 0, N, 1'b0);
        send_word(8'hF0, 8'h00, 1'b1, -1, 0, 2, 1'b0);
        send_word(8'h01, 8'h02, 1'b1, -1, 0, N, 1'b0);
        send_word(8'h7F, 8'h80, 1'b0, -1, 0, N, 1'b0);

        // Random words: near-equal operands, random order, stalls and aborts
        for (int w = 0; w < 200; w++) begin
            ra = 8'($urandom);
            case ($urandom_range(3))
                0: rb = ra;
                1: rb = ra ^ (8'h3 << (2 * $urandom_range(3)));
                default: rb = 8'($urandom);
            endcase
            send_word(ra, rb, 1'($urandom), -1, 0,
                      ($urandom_range(15) == 0) ? int'($urandom_range(N - 1)) : N, 1'b1);
        end

        repeat (3) cycle(1'b0, 2'd0, 2'd0, 1'b0);
        chk("drain_cq",  {2'b0, cq.size()  != 0}, 3'd0);
        chk("drain_rq0", {2'b0, rq0.size() != 0}, 3'd0);
        chk("drain_rq1", {2'b0, rq1.size() != 0}, 3'd0);
        chk("drain_rq2", {2'b0, rq2.size() != 0}, 3'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_comparator_multi_digit_fsm.md
Name: serial_comparator_multi_digit_fsm

Overview:
- FSM-based serial magnitude comparator, generalised from the 1-bit comparators: operands arrive DIGIT_W bits per cycle, framed into words of WORD_DIGITS digits.
- Per-word selectable order (MSB-first or LSB-first), optional two's-complement mode, valid-qualified input with stalls.
- Gives a combinational running verdict plus a registered per-word result with a one-cycle valid pulse.
- Sits between serial links and downstream control logic that needs a final compare per word.

Parameters:
- DIGIT_W, 1, bits of each operand per cycle (>=1)
- WORD_DIGITS, 8, digits per word (>=1); word width = DIGIT_W*WORD_DIGITS
- SIGNED, 0, 1 = operands are two's complement; 0 = unsigned

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous active-high reset
- valid  in  1  a/b/msb_first carry a digit this cycle
- msb_first  in  1  order for the word; sampled only on the word's first digit
- a  in  DIGIT_W  digit of operand A
- b  in  DIGIT_W  digit of operand B
- a_less_b  out  1  running verdict, combinational, one-hot with eq/gt
- a_eq_b  out  1  running verdict
- a_greater_b  out  1  running verdict
- busy  out  1  registered; 1 while a word is partially received (cnt != 0)
- result_valid  out  1  registered one-cycle pulse after a word's last digit
- result_less  out  1  registered word result, held until next word completes
- result_eq  out  1  registered word result
- result_greater  out  1  registered word result

Behaviour:
- Registers:
  - state: st_equal, st_a_less_b, st_a_greater_b (2-bit enum)
  - digit counter cnt: 0..WORD_DIGITS-1
  - mode register: holds order for the current word
  - result flags, result_valid
- Reset: state=st_equal, cnt=0, busy=0, result_valid=0, result_{less,eq,greater}=0,1,0.
- Effective order: eff_msb = msb_first when cnt==0, else mode register. Load mode register with msb_first on a valid first digit. msb_first changes mid-word are ignored.
- Digit compare (dcmp): unsigned compare of a vs b.
  - Sign digit: cnt==0 if eff_msb, cnt==WORD_DIGITS-1 if LSB-first.
  - If SIGNED=1 and the current digit is the sign digit, invert bit DIGIT_W-1 of both digits before comparing.
- Running verdict (v):
  - valid=0: v=state.
  - valid=1 and eff_msb: v = dcmp if state==st_equal, else v = state.
  - valid=1 and LSB-first: v = dcmp if dcmp!=equal, else v = state.
  - Outputs are always exactly one-hot.
- Sequencing, on posedge when valid=1 and rst=0:
  - If cnt==WORD_DIGITS-1 (last digit): result flags<=v, result_valid<=1, state<=st_equal, cnt<=0.
  - Otherwise: state<=v, cnt<=cnt+1.
- valid=0: state, cnt and mode hold; result_valid<=0.
- result_valid is high for exactly one cycle per completed word. Back-to-back words need no idle cycle; the next word's first digit may arrive the cycle after the last.
- WORD_DIGITS=1: every valid digit is both first and last; cnt stays 0; result every valid cycle. The sign digit is that digit in either order.
- Reset mid-word: partial word discarded, no result_valid. The next valid digit starts a new word.
- rst has priority over valid in the same cycle.
- busy = (cnt!=0), registered via cnt.

Test Plan (DIGIT_W=2, WORD_DIGITS=4 unless stated):
- MSB-first unsigned, a=8'hA5 (10,10,01,01), b=8'hA3 (10,10,00,11) -> running eq,eq,gt,gt; result_valid pulse the cycle after digit 4 with result_greater=1; busy 0,1,1,1,0.
- LSB-first same values, a digits 01,01,10,10 and b digits 11,00,10,10 -> running lt,gt,gt,gt; result_greater=1. Toggling msb_first during digits 2-4 has no effect.
- SIGNED=1, MSB-first, a=8'h80 (-128), b=8'h01 -> first digit verdict lt, result_less=1. SIGNED=0 instance with same stimulus -> result_greater=1. LSB-first SIGNED=1, a=8'hFF, b=8'h00 -> result_less=1.
- Stalls: case 1 with valid=0 for 3 cycles between digits 2 and 3 -> state, cnt and running outputs hold (eq during stall); same final result; result_valid pulses once.
- Back-to-back words: 8'h3C vs 8'h3C immediately followed by 8'h10 vs 8'h20 (MSB-first) -> result_eq=1 pulse, then 4 cycles later result_less=1 pulse; second word starts from st_equal.
- Reset after 2 digits of a=8'hF0, b=8'h00 (state gt), then full word 8'h01 vs 8'h02 -> no result_valid for the aborted word; next result_less=1. DIGIT_W=1, WORD_DIGITS=1: a=1, b=0 -> result_greater pulse each valid cycle.
